// File: rtl/mem_arbiter.sv
// Three-way SDRAM port arbiter (VDU > CPU > download) with a download starvation guard.
// Optional WAIT-state watchdog enabled by defining ARB_WATCHDOG_EN.
module mem_arbiter #(
    parameter logic [17:0] VBASE  = 18'h04000,
    parameter bit          ROM_WP = 1'b1,
    parameter logic [2:0]  STARVE = 3'd4
`ifdef ARB_WATCHDOG_EN
    ,
    parameter int          WDT_W  = 6
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vReq,
    input  logic [12:0] vA,
    output logic        vAck,
    output logic [7:0]  vQ,
    input  logic        cReq,
    input  logic        cWe,
    input  logic [15:0] cA,
    input  logic [7:0]  cD,
    output logic        cAck,
    output logic [7:0]  cQ,
    input  logic        dReq,
    input  logic [17:0] dA,
    input  logic [7:0]  dD,
    output logic        dAck,
    output logic        mReq,
    output logic        mWe,
    output logic [17:0] mA,
    output logic [7:0]  mD,
    input  logic [7:0]  mQ,
    input  logic        mRdy,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_VDU, G_CPU, G_DL} grant_t;

    state_t     state;
    grant_t     grant;
    logic [2:0] starve;
    logic       rom_drop;
    logic       dl_first;

`ifdef ARB_WATCHDOG_EN
    logic [WDT_W-1:0] wdt;
`else
    assign err = 1'b0;
`endif

    function automatic logic [2:0] starve_inc(input logic [2:0] s);
        return (s == STARVE) ? s : s + 3'd1;
    endfunction

    assign rom_drop = ROM_WP && cWe && (cA[15:14] == 2'b00);
    assign dl_first = dReq && (starve == STARVE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= G_NONE;
            starve <= 3'd0;
            mReq   <= 1'b0;
            mWe    <= 1'b0;
            mA     <= 18'd0;
            mD     <= 8'd0;
            vAck   <= 1'b0;
            cAck   <= 1'b0;
            dAck   <= 1'b0;
            vQ     <= 8'd0;
            cQ     <= 8'd0;
            busy   <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wdt    <= '0;
            err    <= 1'b0;
`endif
        end else begin
            mReq <= 1'b0;
            vAck <= 1'b0;
            cAck <= 1'b0;
            dAck <= 1'b0;
            case (state)
                // IDLE: arbitrate and latch the winning command
                IDLE: begin
                    if (!dReq)
                        starve <= 3'd0;
                    if (vReq) begin
                        grant <= G_VDU;
                        mA    <= {VBASE[17:13], vA};
                        mWe   <= 1'b0;
                        mReq  <= 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end else if (cReq && !dl_first) begin
                        grant <= G_CPU;
                        busy  <= 1'b1;
                        if (dReq)
                            starve <= starve_inc(starve);
                        if (rom_drop) begin
                            // Dropped ROM write: skip the controller but still ack
                            cAck  <= 1'b1;
                            state <= DONE;
                        end else begin
                            mA    <= {2'b00, cA};
                            mD    <= cD;
                            mWe   <= cWe;
                            mReq  <= 1'b1;
                            state <= ISSUE;
                        end
                    end else if (dReq) begin
                        grant  <= G_DL;
                        mA     <= dA;
                        mD     <= dD;
                        mWe    <= 1'b1;
                        starve <= 3'd0;
                        mReq   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                // ISSUE: command strobe is high for this single cycle
                ISSUE: begin
`ifdef ARB_WATCHDOG_EN
                    wdt   <= {{(WDT_W-1){1'b0}}, 1'b1};
`endif
                    state <= WAIT;
                end
                // WAIT: hold the command until the controller completes
                WAIT: begin
                    if (mRdy) begin
                        if (grant == G_VDU) vQ <= mQ;
                        if (grant == G_CPU) cQ <= mQ;
                        vAck  <= (grant == G_VDU);
                        cAck  <= (grant == G_CPU);
                        dAck  <= (grant == G_DL);
                        state <= DONE;
                    end
`ifdef ARB_WATCHDOG_EN
                    else if (wdt == '1) begin
                        err <= 1'b1;
                        if (grant == G_VDU) vQ <= 8'hFF;
                        if (grant == G_CPU) cQ <= 8'hFF;
                        vAck  <= (grant == G_VDU);
                        cAck  <= (grant == G_CPU);
                        dAck  <= (grant == G_DL);
                        state <= DONE;
                    end else begin
                        wdt <= wdt + 1'b1;
                    end
`endif
                end
                // DONE: ack is high for this single cycle
                DONE: begin
                    grant <= G_NONE;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a reactive SDRAM controller model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        vReq = 1'b0, cReq = 1'b0, cWe = 1'b0, dReq = 1'b0, mRdy;
    logic [12:0] vA = '0;
    logic [15:0] cA = '0;
    logic [7:0]  cD = '0, dD = '0, mQ;
    logic [17:0] dA = '0;
    logic        vAck, cAck, dAck, mReq, mWe, busy, err;
    logic [7:0]  vQ, cQ, mD;
    logic [17:0] mA;

    int          n_checks = 0;
    int          n_fail = 0;

    // Controller model state
    bit          mem_en = 1'b1;
    int          mem_delay = 1;
    logic [7:0]  rd_data = 8'h00;
    int          mreq_cnt = 0;
    logic [17:0] last_a = '0;
    logic        last_we = 1'b0;
    logic [7:0]  last_d = '0;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .vReq(vReq), .vA(vA), .vAck(vAck), .vQ(vQ),
        .cReq(cReq), .cWe(cWe), .cA(cA), .cD(cD), .cAck(cAck), .cQ(cQ),
        .dReq(dReq), .dA(dA), .dD(dD), .dAck(dAck),
        .mReq(mReq), .mWe(mWe), .mA(mA), .mD(mD), .mQ(mQ), .mRdy(mRdy),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    // mRdy pulses mem_delay cycles after the mReq cycle
    initial begin
        mRdy = 1'b0;
        mQ   = 8'h00;
        forever begin
            @(negedge clock);
            mRdy = 1'b0;
            if (mReq) begin
                mreq_cnt++;
                last_a  = mA;
                last_we = mWe;
                last_d  = mD;
                if (mem_en) begin
                    repeat (mem_delay) @(negedge clock);
                    mRdy = 1'b1;
                    mQ   = rd_data;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (mReq !== 1'b0) begin n_fail++; $display("FAIL reset_mreq: got %b want 0", mReq); end
        n_checks++; if ({vAck, cAck, dAck} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {vAck, cAck, dAck}); end
        n_checks++; if (mA !== 18'h0 || mD !== 8'h0) begin n_fail++; $display("FAIL reset_mad: got %h/%h want 0/0", mA, mD); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_cpu_read();
        int base, lat;
        bit got;
        rd_data = 8'h5A; mem_delay = 2; mem_en = 1'b1;
        base = mreq_cnt; got = 1'b0; lat = 0;
        cA = 16'h8000; cWe = 1'b0; cReq = 1'b1;
        while (!got && lat < 20) begin
            @(negedge clock); lat++;
            if (cAck) got = 1'b1;
        end
        cReq = 1'b0;
        n_checks++; if (!got || lat != 4) begin n_fail++; $display("FAIL cpu_read_latency: got ack=%b at %0d want ack at 4", got, lat); end
        n_checks++; if (cQ !== 8'h5A) begin n_fail++; $display("FAIL cpu_read_data: got %h want 5a", cQ); end
        n_checks++; if (last_a !== 18'h08000 || last_we !== 1'b0) begin n_fail++; $display("FAIL cpu_read_cmd: got a=%h we=%b want 08000/0", last_a, last_we); end
        n_checks++; if (mreq_cnt - base != 1) begin n_fail++; $display("FAIL cpu_read_mreq_count: got %0d want 1", mreq_cnt - base); end
        @(negedge clock);
        n_checks++; if (cAck !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cpu_read_done: got ack=%b busy=%b want 0/0", cAck, busy); end
    endtask

    task automatic test_vdu_cpu_priority();
        logic [17:0] a0, a1;
        int nreq, vcnt, ccnt, vord, cord, idx;
        logic [7:0] vq_s, cq_s;
        nreq = 0; vcnt = 0; ccnt = 0; vord = -1; cord = -1; idx = 0;
        a0 = '0; a1 = '0; vq_s = '0; cq_s = '0;
        rd_data = 8'h3C; mem_delay = 1;
        vA = 13'h0001; vReq = 1'b1;
        cA = 16'hC000; cWe = 1'b0; cReq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mReq) begin
                if (nreq == 0) a0 = mA;
                if (nreq == 1) a1 = mA;
                nreq++;
            end
            if (vAck) begin vcnt++; vord = idx++; vq_s = vQ; vReq = 1'b0; end
            if (cAck) begin ccnt++; cord = idx++; cq_s = cQ; cReq = 1'b0; end
        end
        vReq = 1'b0; cReq = 1'b0;
        n_checks++; if (a0 !== 18'h04001) begin n_fail++; $display("FAIL prio_vdu_addr: got %h want 04001", a0); end
        n_checks++; if (a1 !== 18'h0C000) begin n_fail++; $display("FAIL prio_cpu_addr: got %h want 0c000", a1); end
        n_checks++; if (vcnt != 1 || ccnt != 1) begin n_fail++; $display("FAIL prio_ack_counts: got v=%0d c=%0d want 1/1", vcnt, ccnt); end
        n_checks++; if (vord != 0 || cord != 1) begin n_fail++; $display("FAIL prio_order: got v=%0d c=%0d want 0/1", vord, cord); end
        n_checks++; if (vq_s !== 8'h3C || cq_s !== 8'h3C) begin n_fail++; $display("FAIL prio_data: got v=%h c=%h want 3c/3c", vq_s, cq_s); end
    endtask

    task automatic test_rom_protect();
        int base, lat;
        bit got;
        base = mreq_cnt;
        cA = 16'h1234; cD = 8'h55; cWe = 1'b1; cReq = 1'b1;
        @(negedge clock);
        n_checks++; if (cAck !== 1'b1) begin n_fail++; $display("FAIL rom_ack: got %b want 1", cAck); end
        cReq = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (mreq_cnt != base) begin n_fail++; $display("FAIL rom_no_mreq: got %0d strobes want 0", mreq_cnt - base); end
        n_checks++; if (cQ !== 8'h3C) begin n_fail++; $display("FAIL rom_cq_kept: got %h want 3c", cQ); end
        cA = 16'h4000; cD = 8'hAA; cWe = 1'b1; cReq = 1'b1;
        got = 1'b0; lat = 0;
        while (!got && lat < 20) begin
            @(negedge clock); lat++;
            if (cAck) got = 1'b1;
        end
        cReq = 1'b0; cWe = 1'b0;
        n_checks++; if (!got) begin n_fail++; $display("FAIL ram_write_ack: got none want ack"); end
        n_checks++; if (last_a !== 18'h04000 || last_we !== 1'b1 || last_d !== 8'hAA) begin n_fail++; $display("FAIL ram_write_cmd: got a=%h we=%b d=%h want 04000/1/aa", last_a, last_we, last_d); end
        n_checks++; if (mreq_cnt - base != 1) begin n_fail++; $display("FAIL ram_write_mreq: got %0d want 1", mreq_cnt - base); end
        @(negedge clock);
    endtask

    task automatic test_starvation();
        logic [1:0]  seq [0:7];
        logic [17:0] addr [0:7];
        logic [11:0] code;
        int nack, nreq, cyc;
        nack = 0; nreq = 0; cyc = 0;
        for (int i = 0; i < 8; i++) begin seq[i] = 2'b00; addr[i] = '0; end
        mem_delay = 1;
        dA = 18'h2ABCD; dD = 8'h99; dReq = 1'b1;
        cA = 16'h8010; cWe = 1'b0; cReq = 1'b1;
        while (nack < 6 && cyc < 200) begin
            @(negedge clock); cyc++;
            if (mReq && nreq < 8) begin addr[nreq] = mA; nreq++; end
            if (cAck) begin seq[nack] = 2'b01; nack++; end
            if (dAck) begin seq[nack] = 2'b10; nack++; dReq = 1'b0; end
        end
        cReq = 1'b0; dReq = 1'b0;
        code = {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]};
        n_checks++; if (nack != 6) begin n_fail++; $display("FAIL starve_ack_count: got %0d want 6", nack); end
        n_checks++; if (code !== 12'b01_01_01_01_10_01) begin n_fail++; $display("FAIL starve_order: got %b want 010101011001", code); end
        n_checks++; if (addr[4] !== 18'h2ABCD || addr[5] !== 18'h08010) begin n_fail++; $display("FAIL starve_addr: got dl=%h next=%h want 2abcd/08010", addr[4], addr[5]); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_access();
        int cyc, acks;
        bit got;
        mem_en = 1'b0; cyc = 0; acks = 0; got = 1'b0;
        cA = 16'h0100; cWe = 1'b0; cReq = 1'b1;
        while (!got && cyc < 10) begin
            @(negedge clock); cyc++;
            if (mReq) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL midrst_issue: got no mReq want one"); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if ({busy, mReq, mWe, cAck, vAck, dAck} !== 6'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b want 000000", {busy, mReq, mWe, cAck, vAck, dAck}); end
        n_checks++; if (mA !== 18'h0 || mD !== 8'h0 || cQ !== 8'h0 || vQ !== 8'h0) begin n_fail++; $display("FAIL midrst_data: got %h %h %h %h want zeros", mA, mD, cQ, vQ); end
        cReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (cAck) acks++;
        end
        reset = 1'b1; mem_en = 1'b1; rd_data = 8'h77; mem_delay = 1;
        @(negedge clock);
        cReq = 1'b1; got = 1'b0; cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clock); cyc++;
            if (cAck) got = 1'b1;
        end
        cReq = 1'b0;
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d acks want 0", acks); end
        n_checks++; if (!got || cQ !== 8'h77 || last_a !== 18'h00100) begin n_fail++; $display("FAIL midrst_recover: got ack=%b q=%h a=%h want 1/77/00100", got, cQ, last_a); end
        @(negedge clock);
    endtask

`ifdef ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int cyc, n;
        bit got, ack;
        mem_en = 1'b0; got = 1'b0; ack = 1'b0; cyc = 0; n = 0;
        cA = 16'h2000; cWe = 1'b0; cReq = 1'b1;
        while (!got && cyc < 10) begin
            @(negedge clock); cyc++;
            if (mReq) got = 1'b1;
        end
        while (got && !ack && n < 200) begin
            @(negedge clock); n++;
            if (cAck) ack = 1'b1;
        end
        cReq = 1'b0;
        n_checks++; if (!ack || n != 64) begin n_fail++; $display("FAIL wdt_latency: got ack=%b at %0d want ack at 64", ack, n); end
        n_checks++; if (cQ !== 8'hFF || err !== 1'b1) begin n_fail++; $display("FAIL wdt_result: got q=%h err=%b want ff/1", cQ, err); end
        repeat (5) @(negedge clock);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL wdt_sticky: got %b want 1", err); end
        reset = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wdt_clear: got %b want 0", err); end
        @(negedge clock);
        reset = 1'b1; mem_en = 1'b1;
        @(negedge clock);
    endtask
`else
    task automatic test_err_tied();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_tied: got %b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_vdu_cpu_priority();
        test_rom_protect();
        test_starvation();
        test_reset_mid_access();
`ifdef ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_err_tied();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
